// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the line-granular data memory.
package data_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int LINE_BYTES = 32;
    localparam int OFFSET_W   = 5;
    // Widest byte address supported; narrower addresses are zero-extended.
    localparam int ADDR_MAX   = 64;
    localparam int IDX_W      = ADDR_MAX - OFFSET_W;

    // Line index of a byte address: drops the byte-in-line offset bits.
    function automatic logic [IDX_W-1:0] line_index(input logic [ADDR_MAX-1:0] addr);
        return IDX_W'(addr >> OFFSET_W);
    endfunction

endpackage

// File: rtl/data_memory_line_if.sv
// Enable/ack line bus between the dcache memory port and the data memory.
interface data_memory_line_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    logic              mem_enable_i;
    logic              mem_write_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_o;
    logic [LINE_W-1:0] mem_data_o;

    modport master (
        output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        input  mem_ack_o, mem_data_o
    );

    modport slave (
        input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
        output mem_ack_o, mem_data_o
    );
endinterface

// File: rtl/dm_latency_counter.sv
// Access-latency down counter: load with LATENCY-1, decrement, done at 1.
module dm_latency_counter #(
    parameter int LATENCY = 10,
    parameter int CNT_W   = $clog2(LATENCY + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_load,
    input  logic i_dec,
    output logic o_done
);
    logic [CNT_W-1:0] r_cnt;

    // Counter register: load takes priority over decrement.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(LATENCY - 1);
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/data_memory_line.sv
// Line-granular data memory with fixed access latency behind the dcache.
// Optional range checking of line indices: DATA_MEMORY_RANGE_CHECK_EN.
module data_memory_line
    import data_memory_pkg::*;
#(
    parameter int LINE_W  = 256,
    parameter int ADDR_W  = 32,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    data_memory_line_if.slave  mem_if,
    output logic               err_o
);
    localparam int ROW_W = $clog2(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_dec;
    logic                w_done;
    logic                w_enter_ack;

    logic [ADDR_W-1:0]   w_addr;
    logic [IDX_W-1:0]    w_idx;
    logic [ROW_W-1:0]    w_in_row;
    logic                w_in_oor;

    logic [ROW_W-1:0]    r_row;
    logic                r_wr;
    logic [LINE_W-1:0]   r_wdata;
    logic                r_oor;

    logic [ROW_W-1:0]    w_row_sel;
    logic                w_wr_sel;
    logic [LINE_W-1:0]   w_wdata_sel;
    logic                w_oor_sel;
    logic                w_commit;

    logic [LINE_W-1:0]   r_mem [DEPTH];
    logic [LINE_W-1:0]   r_data_o;

    assign w_addr   = mem_if.mem_addr_i;
    assign w_idx    = line_index(ADDR_MAX'(w_addr));
    assign w_in_row = ROW_W'(w_idx % IDX_W'(DEPTH));
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    assign w_in_oor = (w_idx >= IDX_W'(DEPTH));
`else
    assign w_in_oor = 1'b0;
`endif

    dm_latency_counter #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_done (w_done)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dec       = 1'b0;
        w_enter_ack = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_if.mem_enable_i) begin
                    w_load = 1'b1;
                    if (LATENCY == 1) begin
                        w_state_nxt = ACK;
                        w_enter_ack = 1'b1;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (w_done) begin
                    w_state_nxt = ACK;
                    w_enter_ack = 1'b1;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // With LATENCY=1 the ack edge is also the capture edge, so the live
    // request is used instead of the not-yet-loaded capture registers.
    always_comb begin
        w_row_sel   = r_row;
        w_wr_sel    = r_wr;
        w_wdata_sel = r_wdata;
        w_oor_sel   = r_oor;
        if (r_state == IDLE) begin
            w_row_sel   = w_in_row;
            w_wr_sel    = mem_if.mem_write_i;
            w_wdata_sel = mem_if.mem_data_i;
            w_oor_sel   = w_in_oor;
        end
    end

    // Reset gating keeps an aborted transaction from committing.
    assign w_commit = rst_i & w_enter_ack & w_wr_sel & ~w_oor_sel;

    // Capture the request in IDLE; later input changes are ignored.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_row   <= '0;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_oor   <= 1'b0;
        end else if (r_state == IDLE && mem_if.mem_enable_i) begin
            r_row   <= w_in_row;
            r_wr    <= mem_if.mem_write_i;
            r_wdata <= mem_if.mem_data_i;
            r_oor   <= w_in_oor;
        end
    end

    // Line array: contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_commit) begin
            r_mem[w_row_sel] <= w_wdata_sel;
        end
    end

    // Read data loads at the ack edge of reads only and is held otherwise.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_data_o <= '0;
        end else if (w_enter_ack && !w_wr_sel) begin
            r_data_o <= w_oor_sel ? '0 : r_mem[w_row_sel];
        end
    end

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    logic r_err;

    // Sticky out-of-range flag, raised at the ack edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_enter_ack && w_oor_sel) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign mem_if.mem_ack_o  = (r_state == ACK);
    assign mem_if.mem_data_o = r_data_o;
endmodule

// File: tb/tb_data_memory_line.sv
// Directed bench for data_memory_line: LATENCY=10 and LATENCY=1 instances.
module tb_data_memory_line;

    logic clk;
    logic rst_n;
    logic err0;
    logic err1;

    int checks = 0;
    int errors = 0;

`ifdef DATA_MEMORY_RANGE_CHECK_EN
    localparam bit RC_EN = 1'b1;
`else
    localparam bit RC_EN = 1'b0;
`endif

    data_memory_line_if #(.LINE_W(256), .ADDR_W(32)) bus0 ();
    data_memory_line_if #(.LINE_W(256), .ADDR_W(32)) bus1 ();

    data_memory_line #(
        .LINE_W  (256),
        .ADDR_W  (32),
        .DEPTH   (512),
        .LATENCY (10)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .mem_if (bus0),
        .err_o  (err0)
    );

    data_memory_line #(
        .LINE_W  (256),
        .ADDR_W  (32),
        .DEPTH   (512),
        .LATENCY (1)
    ) dut1 (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .mem_if (bus1),
        .err_o  (err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %0s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the selected instance; returns the edge count
    // from capture (capture edge = 1) to the cycle where ack is seen.
    task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [255:0] wdata, output int lat,
                       output logic [255:0] rdata);
        logic ack;
        lat   = 0;
        rdata = '0;
        if (sel) begin
            bus1.mem_enable_i = 1'b1;
            bus1.mem_write_i  = wr;
            bus1.mem_addr_i   = addr;
            bus1.mem_data_i   = wdata;
        end else begin
            bus0.mem_enable_i = 1'b1;
            bus0.mem_write_i  = wr;
            bus0.mem_addr_i   = addr;
            bus0.mem_data_i   = wdata;
        end
        for (int k = 1; k <= 40; k++) begin
            step();
            ack = sel ? bus1.mem_ack_o : bus0.mem_ack_o;
            if (ack) begin
                lat   = k;
                rdata = sel ? bus1.mem_data_o : bus0.mem_data_o;
                break;
            end
        end
        bus0.mem_enable_i = 1'b0;
        bus1.mem_enable_i = 1'b0;
        step();
        check("ack_one_cycle", sel ? bus1.mem_ack_o : bus0.mem_ack_o, 256'(0));
    endtask

    initial begin
        logic [255:0] pat_a5, pat_12, pat_5a, pat_c3, pat_77, pat_ee, pat_0f;
        logic [255:0] rd, d1, d2;
        int lat, a1, a2, n_ack;
        bit saw_ack;

        pat_a5 = {32{8'hA5}};
        pat_12 = {16{16'h1234}};
        pat_5a = {32{8'h5A}};
        pat_c3 = {32{8'hC3}};
        pat_77 = {32{8'h77}};
        pat_ee = {32{8'hEE}};
        pat_0f = {32{8'h0F}};

        rst_n = 1'b0;
        bus0.mem_enable_i = 1'b0; bus0.mem_write_i = 1'b0;
        bus0.mem_addr_i = '0;     bus0.mem_data_i = '0;
        bus1.mem_enable_i = 1'b0; bus1.mem_write_i = 1'b0;
        bus1.mem_addr_i = '0;     bus1.mem_data_i = '0;

        // Reset state.
        step(); step();
        check("rst_ack",   bus0.mem_ack_o,  256'(0));
        check("rst_data",  bus0.mem_data_o, 256'(0));
        check("rst_err",   err0,            256'(0));
        check("rst_ack1",  bus1.mem_ack_o,  256'(0));
        check("rst_data1", bus1.mem_data_o, 256'(0));
        rst_n = 1'b1;
        step();

        // Preload row of 0x40, then read it back.
        txn(1'b0, 1'b1, 32'h40, pat_a5, lat, rd);
        check("wr40_lat", 256'(lat), 256'(10));
        check("wr40_data_held", rd, 256'(0));
        txn(1'b0, 1'b0, 32'h40, '0, lat, rd);
        check("rd40_lat", 256'(lat), 256'(10));
        check("rd40_data", rd, pat_a5);

        // Write then read 0x80; write must not touch read data.
        txn(1'b0, 1'b1, 32'h80, pat_12, lat, rd);
        check("wr80_lat", 256'(lat), 256'(10));
        check("wr80_data_held", rd, pat_a5);
        txn(1'b0, 1'b0, 32'h80, '0, lat, rd);
        check("rd80_data", rd, pat_12);

        // Enable held across ack: second request switched in during ack cycle.
        n_ack = 0; a1 = 0; a2 = 0; d1 = '0; d2 = '0;
        bus0.mem_enable_i = 1'b1;
        bus0.mem_write_i  = 1'b0;
        bus0.mem_addr_i   = 32'h40;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (bus0.mem_ack_o) begin
                n_ack++;
                if (n_ack == 1) begin
                    a1 = k;
                    d1 = bus0.mem_data_o;
                    bus0.mem_addr_i = 32'h80;
                end else if (n_ack == 2) begin
                    a2 = k;
                    d2 = bus0.mem_data_o;
                    bus0.mem_enable_i = 1'b0;
                end
            end
        end
        check("b2b_ack1_pos", 256'(a1), 256'(10));
        check("b2b_ack2_pos", 256'(a2), 256'(21));
        check("b2b_ack_count", 256'(n_ack), 256'(2));
        check("b2b_data1", d1, pat_a5);
        check("b2b_data2", d2, pat_12);

        // Reset five edges after capture aborts a write.
        txn(1'b0, 1'b1, 32'h100, pat_5a, lat, rd);
        check("wr100_lat", 256'(lat), 256'(10));
        saw_ack = 1'b0;
        bus0.mem_enable_i = 1'b1;
        bus0.mem_write_i  = 1'b1;
        bus0.mem_addr_i   = 32'h100;
        bus0.mem_data_i   = pat_c3;
        for (int k = 0; k <= 5; k++) begin
            step();
            if (bus0.mem_ack_o) saw_ack = 1'b1;
        end
        rst_n = 1'b0;
        bus0.mem_enable_i = 1'b0;
        #1;
        check("abort_data_zero", bus0.mem_data_o, 256'(0));
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus0.mem_ack_o) saw_ack = 1'b1;
        end
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            step();
            if (bus0.mem_ack_o) saw_ack = 1'b1;
        end
        check("abort_no_ack", 256'(saw_ack), 256'(0));
        txn(1'b0, 1'b0, 32'h100, '0, lat, rd);
        check("abort_rd100", rd, pat_5a);

        // Index 512 (addr 0x4000): wraps to row 0 or is rejected.
        txn(1'b0, 1'b1, 32'h0, pat_77, lat, rd);
        check("err_before", err0, 256'(0));
        txn(1'b0, 1'b1, 32'h4000, pat_ee, lat, rd);
        check("oor_wr_lat", 256'(lat), 256'(10));
        check("oor_err", err0, RC_EN ? 256'(1) : 256'(0));
        txn(1'b0, 1'b0, 32'h0, '0, lat, rd);
        check("row0_data", rd, RC_EN ? pat_77 : pat_ee);
        txn(1'b0, 1'b0, 32'h4000, '0, lat, rd);
        check("oor_rd_data", rd, RC_EN ? 256'(0) : pat_ee);
        check("oor_rd_lat", 256'(lat), 256'(10));
        step(); step();
        check("err_sticky", err0, RC_EN ? 256'(1) : 256'(0));

        // LATENCY=1 instance.
        txn(1'b1, 1'b1, 32'h20, pat_0f, lat, rd);
        check("l1_wr_lat", 256'(lat), 256'(1));
        txn(1'b1, 1'b0, 32'h20, '0, lat, rd);
        check("l1_rd_lat", 256'(lat), 256'(1));
        check("l1_rd_data", rd, pat_0f);
        check("l1_err", err1, 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
